// File: rtl/f2m_inv_if.sv
// f2m_inv_if: request/response bundle of the F(2^m) inverter.
// The requester drives start/a; the inverter returns busy/done/z.
interface f2m_inv_if #(
    parameter int M = 163
);
    logic         start;
    logic [M-1:0] a;
    logic         busy;
    logic         done;
    logic [M-1:0] z;

    modport master (
        output start, a,
        input  busy, done, z
    );

    modport slave (
        input  start, a,
        output busy, done, z
    );
endinterface

// File: rtl/f2m_inv.sv
// f2m_inv: sequential F(2^m) inverter, modified Stein/Brunner algorithm.
// f2m_inv_dp is the combinational datapath, two iterations per clock.
module f2m_inv_dp #(
    parameter int M       = 163,
    parameter int D_WIDTH = 9
) (
    input  logic [M:0]         r_i,
    input  logic [M:0]         s_i,
    input  logic [M:0]         u_i,
    input  logic [M:0]         v_i,
    input  logic [D_WIDTH-1:0] d_i,
    output logic [M:0]         r_o,
    output logic [M:0]         s_o,
    output logic [M:0]         u_o,
    output logic [M:0]         v_o,
    output logic [D_WIDTH-1:0] d_o
);
    typedef struct packed {
        logic [M:0]         r;
        logic [M:0]         s;
        logic [M:0]         u;
        logic [M:0]         v;
        logic [D_WIDTH-1:0] d;
    } st_t;

    localparam logic [D_WIDTH-1:0] D_ONE = D_WIDTH'(1);

    // u stays divisible by x^d, so the right shift below is exact
    function automatic st_t step(input st_t x);
        st_t y;
        y = x;
        if (!x.r[M]) begin
            y.r = x.r << 1;
            y.u = x.u << 1;
            y.d = x.d + D_ONE;
        end else begin
            if (x.s[M]) begin
                y.s = x.s ^ x.r;
                y.v = x.v ^ x.u;
            end
            y.s = y.s << 1;
            if (x.d == '0) begin
                y.r = y.s;
                y.s = x.r;
                y.u = y.v << 1;
                y.v = x.u;
                y.d = D_ONE;
            end else begin
                y.u = x.u >> 1;
                y.d = x.d - D_ONE;
            end
        end
        return y;
    endfunction

    st_t st0, st1, st2;

    always_comb begin
        st0 = '{r: r_i, s: s_i, u: u_i, v: v_i, d: d_i};
        st1 = step(st0);
        st2 = step(st1);
        r_o = st2.r;
        s_o = st2.s;
        u_o = st2.u;
        v_o = st2.v;
        d_o = st2.d;
    end
endmodule

module f2m_inv #(
    parameter int         M       = 163,
    parameter logic [M:0] F       = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9,
    parameter int         D_WIDTH = 9
) (
    input  logic     clk,
    input  logic     rst,
    f2m_inv_if.slave io
);
    localparam int            CW       = $clog2(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [M:0]         r_q, r_d;
    logic [M:0]         s_q, s_d;
    logic [M:0]         u_q, u_d;
    logic [M:0]         v_q, v_d;
    logic [D_WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [M-1:0]       z_q, z_d;

    logic [M:0]         dp_r, dp_s, dp_u, dp_v;
    logic [D_WIDTH-1:0] dp_d;

    f2m_inv_dp #(
        .M      (M),
        .D_WIDTH(D_WIDTH)
    ) u_dp (
        .r_i(r_q),
        .s_i(s_q),
        .u_i(u_q),
        .v_i(v_q),
        .d_i(d_q),
        .r_o(dp_r),
        .s_o(dp_s),
        .u_o(dp_u),
        .v_o(dp_v),
        .d_o(dp_d)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        s_d     = s_q;
        u_d     = u_q;
        v_d     = v_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        z_d     = z_q;
        unique case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d = RUN;
                    r_d     = {1'b0, io.a};
                    s_d     = F;
                    u_d     = (M + 1)'(1);
                    v_d     = '0;
                    d_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                r_d   = dp_r;
                s_d   = dp_s;
                u_d   = dp_u;
                v_d   = dp_v;
                d_d   = dp_d;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    z_d     = dp_u[M-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            s_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            s_q     <= s_d;
            u_q     <= u_d;
            v_q     <= v_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.z    = z_q;
endmodule

// File: tb/tb_f2m_inv.sv
// tb_f2m_inv: directed and random checks of the F(2^m) inverter,
// default field plus a tiny M=2 instance.
module tb_f2m_inv;
    localparam int         M = 163;
    localparam logic [M:0] F = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9;

    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;
    int   n_acc  = 0;
    int   n_done = 0;

    f2m_inv_if #(.M(M)) io ();
    f2m_inv_if #(.M(2)) sio ();

    f2m_inv #(.M(M), .F(F), .D_WIDTH(9)) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    f2m_inv #(.M(2), .F(3'b111), .D_WIDTH(3)) dut_s (
        .clk(clk),
        .rst(rst),
        .io (sio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] obs,
                       input logic [191:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Horner multiply mod F, independent of the inversion algorithm
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x,
                                            input logic [M-1:0] y);
        logic [M:0] acc;
        acc = '0;
        for (int i = M - 1; i >= 0; i--) begin
            acc = acc << 1;
            if (acc[M]) acc = acc ^ F;
            if (y[i]) acc = acc ^ {1'b0, x};
        end
        return acc[M-1:0];
    endfunction

    function automatic logic [M-1:0] rnd_a();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[M-1:0];
    endfunction

    task automatic start_op(input logic [M-1:0] av);
        io.start = 1'b1;
        io.a     = av;
        @(negedge clk);
        io.start = 1'b0;
        n_acc++;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (io.done !== 1'b1 && lat < 400) begin
            if (io.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (io.done === 1'b1) n_done++;
    endtask

    initial begin
        int           lat, bc, nd;
        logic [M-1:0] a0, zx;

        zx      = '0;
        zx[162] = 1'b1;
        zx[6]   = 1'b1;
        zx[5]   = 1'b1;
        zx[2]   = 1'b1;

        rst       = 1'b1;
        io.start  = 1'b0;
        io.a      = '0;
        sio.start = 1'b0;
        sio.a     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", io.busy, 0);
        chk("rst_done", io.done, 0);
        chk("rst_z", io.z, 0);
        rst = 1'b0;
        @(negedge clk);

        sio.start = 1'b1;
        sio.a     = 2'b10;
        @(negedge clk);
        sio.start = 1'b0;
        sio.a     = 2'b01;
        chk("s_busy", sio.busy, 1);
        @(negedge clk);
        chk("s_u1", dut_s.u_q, 3'b001);
        chk("s_done_early", sio.done, 0);
        @(negedge clk);
        chk("s_done", sio.done, 1);
        chk("s_z", sio.z, 2'b11);
        chk("s_busy_end", sio.busy, 0);
        @(negedge clk);
        chk("s_done_pulse", sio.done, 0);
        chk("s_z_hold", sio.z, 2'b11);

        start_op(1);
        chk("a1_busy", io.busy, 1);
        wait_done(lat, bc);
        chk("a1_lat", lat, M);
        chk("a1_z", io.z, 1);

        @(negedge clk);
        start_op(2);
        wait_done(lat, bc);
        chk("ax_lat", lat, M);
        chk("ax_busy_cycles", bc, M);
        chk("ax_busy_at_done", io.busy, 0);
        chk("ax_z", io.z, zx);
        @(negedge clk);
        chk("ax_done_pulse", io.done, 0);
        chk("ax_z_hold", io.z, zx);

        start_op(0);
        wait_done(lat, bc);
        chk("a0_lat", lat, M);
        chk("a0_z", io.z, 0);
        start_op(1);
        chk("b2b_busy", io.busy, 1);
        chk("b2b_z_hold", io.z, 0);
        wait_done(lat, bc);
        chk("b2b_lat", lat, M);
        chk("b2b_z", io.z, 1);

        @(negedge clk);
        start_op(2);
        lat = 0;
        bc  = 0;
        while (io.done !== 1'b1 && lat < 400) begin
            if (io.busy !== 1'b1) bc++;
            io.start = (lat % 10 == 9);
            io.a     = rnd_a();
            @(negedge clk);
            lat++;
        end
        io.start = 1'b0;
        chk("ign_lat", lat, M);
        chk("ign_early_drop", bc, 0);
        chk("ign_z", io.z, zx);
        @(negedge clk);
        chk("ign_done_pulse", io.done, 0);
        chk("ign_idle", io.busy, 0);

        start_op(2);
        repeat (79) @(negedge clk);
        chk("pre_abort_busy", io.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", io.busy, 0);
        chk("abort_done", io.done, 0);
        chk("abort_z", io.z, 0);
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        repeat (200) begin
            @(negedge clk);
            if (io.done === 1'b1) nd++;
        end
        chk("abort_no_done", nd, 0);
        start_op(2);
        wait_done(lat, bc);
        chk("fresh_lat", lat, M);
        chk("fresh_z", io.z, zx);

        n_acc  = 0;
        n_done = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            a0 = rnd_a();
            if (a0 == '0) a0 = 1;
            start_op(a0);
            wait_done(lat, bc);
            chk("rnd_lat", lat, M);
            chk("rnd_inv", gf_mul(io.z, a0), 1);
        end
        chk("acc_vs_done", n_done, n_acc);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
